chan_scanner: RTL and testbench
===============================

CHAN_SCANNER -- requirements
Module: chan_scanner

Interface
REQ-001 Parameter: DWELL_W, default 8, width of the per-channel dwell count.
REQ-002 clk  input  1  Single clock; all state updates on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-004 start  input  1  Single-cycle request to begin a scan; honoured only in IDLE.
REQ-005 stop  input  1  Abort request; honoured in any state.
REQ-006 oneshot  input  1  Scan mode, sampled with start: 1 = one pass then IDLE, 0 = continuous.
REQ-007 mask  input  8  Channel enables, bit i enables channel i; sampled with start.
REQ-008 dwell  input  DWELL_W  Extra hold cycles per channel; sampled with start.
REQ-009 sel  output  3  Current channel index; drives the in port of the downstream 3-to-8 decoder.
REQ-010 sel_valid  output  1  High while sel is a live scan selection.
REQ-011 busy  output  1  High in state SCAN.
REQ-012 wrap  output  1  One-cycle pulse on the cycle sel returns to the lowest enabled channel.
REQ-013 done  output  1  One-cycle pulse when a oneshot pass completes.

Function
REQ-014 States SHALL be IDLE and SCAN; all outputs SHALL be registered.
REQ-015 In IDLE: sel=0, sel_valid=0, busy=0, wrap=0.
REQ-016 IDLE->SCAN on start=1, stop=0 and mask!=0. On the next cycle: mask, dwell and oneshot latched; sel = index of the lowest set mask bit; sel_valid=1; busy=1; dwell counter=0.
REQ-017 start with mask==0 SHALL be ignored: stay in IDLE, no output change.
REQ-018 In SCAN the dwell counter SHALL increment each cycle. Each channel SHALL be held for exactly latched_dwell+1 cycles; dwell=0 gives one cycle per channel.
REQ-019 When the counter equals latched_dwell, the next cycle SHALL load sel with the next higher enabled index and clear the counter.
REQ-020 If no higher enabled index exists, the continuous-mode response SHALL be: sel = lowest enabled index and wrap=1 for that one cycle.
REQ-021 If no higher enabled index exists, the oneshot response SHALL be: go to IDLE, done=1 for one cycle, sel=0, sel_valid=0, wrap=0.
REQ-022 With exactly one enabled channel in continuous mode, sel SHALL stay constant and wrap SHALL pulse every latched_dwell+1 cycles.
REQ-023 Changes to mask, dwell or oneshot during SCAN SHALL have no effect until the next start.
REQ-024 start during SCAN SHALL be ignored.
REQ-025 stop=1 in SCAN SHALL force IDLE on the next cycle, with priority over advance, wrap and done; done SHALL NOT pulse on stop.
REQ-026 start and stop asserted together in IDLE: stop wins and the block stays in IDLE.
REQ-027 sel SHALL only ever hold an index whose latched mask bit is 1 while sel_valid=1.
REQ-028 Counter compare SHALL be unsigned, full DWELL_W width; dwell = 2^DWELL_W-1 SHALL NOT overflow.

Reset
REQ-029 rst=1 SHALL force IDLE on the next edge: sel=0, sel_valid=0, busy=0, wrap=0, done=0; dwell counter and latched registers cleared.
REQ-030 rst SHALL take priority over start and stop. Reset asserted mid-scan SHALL abort the scan with no wrap or done pulse.

Verification
REQ-031 mask=8'hFF, dwell=0, oneshot=1, start pulse -> sel 0,1,...,7 on consecutive cycles with sel_valid=1, then done=1 and sel_valid=0 on the next cycle.
REQ-032 mask=8'b1010_0100, dwell=2, oneshot=0 -> sel 2,2,2,5,5,5,7,7,7,2 and so on; wrap=1 only on each return to 2.
REQ-033 mask=8'h10, dwell=1, continuous -> sel=4 constant; wrap pulses every 2 cycles.
REQ-034 stop asserted in the second dwell cycle of channel 5 -> IDLE next cycle, sel=0, sel_valid=0, done=0; a later start restarts from the lowest enabled channel.
REQ-035 mask=0 with start -> no state change; start and stop together in IDLE -> stays IDLE; start during SCAN -> sequence undisturbed.
REQ-036 rst mid-scan -> all outputs 0 next cycle. mask changed to 8'h01 mid-scan -> sequence follows the old latched mask until the next start.

Source files
------------

// File: rtl/chan_scanner_if.sv
// Control and selection bundle between a scan controller (master) and chan_scanner (slave).
// start/stop are level-sampled one-cycle requests with no ready; every output is a registered level or pulse.
interface chan_scanner_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               oneshot;
  logic [7:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         sel;
  logic               sel_valid;
  logic               busy;
  logic               wrap;
  logic               done;

  modport master (
    output start, stop, oneshot, mask, dwell,
    input  sel, sel_valid, busy, wrap, done
  );

  modport slave (
    input  start, stop, oneshot, mask, dwell,
    output sel, sel_valid, busy, wrap, done
  );
endinterface

// File: rtl/chan_scanner.sv
// Round-robin channel scanner: steps sel through the enabled channels of a latched mask,
// holding each channel for dwell+1 cycles, in oneshot or continuous mode.
module chan_scanner #(
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  chan_scanner_if.slave  bus,
  output logic           state_o
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               oneshot_q;
  logic [DWELL_W-1:0] cnt_q;
  logic [2:0]         sel_q;
  logic               sel_valid_q;
  logic               busy_q;
  logic               wrap_q;
  logic               done_q;

  logic [2:0] start_idx_d;
  logic [2:0] low_idx_d;
  logic [2:0] next_idx_d;
  logic       next_found_d;
  logic       dwell_end_d;

  // Lowest set bit of the incoming and latched masks, and the next enabled index above sel.
  always_comb begin
    start_idx_d  = 3'd0;
    low_idx_d    = 3'd0;
    next_idx_d   = 3'd0;
    next_found_d = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.mask[i]) start_idx_d = 3'(i);
      if (mask_q[i]) low_idx_d = 3'(i);
      if (mask_q[i] && (i > int'(sel_q))) begin
        next_idx_d   = 3'(i);
        next_found_d = 1'b1;
      end
    end
    dwell_end_d = (cnt_q == dwell_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      dwell_q     <= '0;
      oneshot_q   <= 1'b0;
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && !bus.stop && (bus.mask != 8'd0)) begin
            state_q     <= SCAN;
            mask_q      <= bus.mask;
            dwell_q     <= bus.dwell;
            oneshot_q   <= bus.oneshot;
            cnt_q       <= '0;
            sel_q       <= start_idx_d;
            sel_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 3'd0;
            sel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (dwell_end_d) begin
            cnt_q <= '0;
            if (next_found_d) begin
              sel_q <= next_idx_d;
            end else if (oneshot_q) begin
              state_q     <= IDLE;
              sel_q       <= 3'd0;
              sel_valid_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              sel_q  <= low_idx_d;
              wrap_q <= 1'b1;
            end
          end else begin
            // cnt_q never passes dwell_q, so the increment cannot overflow.
            cnt_q <= cnt_q + DWELL_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_valid = sel_valid_q;
  assign bus.busy      = busy_q;
  assign bus.wrap      = wrap_q;
  assign bus.done      = done_q;
  assign state_o       = (state_q == SCAN);

endmodule

// File: tb/tb_chan_scanner.sv
// Bench for chan_scanner: a per-cycle reference model pushes the expected outputs as
// stimulus is driven; a monitor pops and compares them after each rising edge.
module tb_chan_scanner;
  localparam int DW = 8;
  localparam int W  = 8;

  logic clk;
  logic rst;
  logic state;

  chan_scanner_if #(.DWELL_W(DW)) bus_if ();

  chan_scanner #(.DWELL_W(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus_if.slave),
    .state_o (state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  string scen     = "reset";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected word: {done, wrap, busy, sel_valid, state, sel}
  function automatic logic [W-1:0] mk_exp(input logic d, input logic w, input logic b,
                                          input logic v, input logic [2:0] s);
    return {d, w, b, v, b, s};
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check_val(scen, {bus_if.done, bus_if.wrap, bus_if.busy, bus_if.sel_valid,
                         state, bus_if.sel}, e);
      end
    end
  end

  // reference model state
  int m_list[$];
  bit m_active = 0;
  int m_pos, m_hold, m_dwell;
  bit m_os;

  // driver: applies one cycle of inputs and queues the output the model predicts
  task automatic tick(input logic st, input logic sp, input logic os,
                      input logic [7:0] mk, input logic [DW-1:0] dw, input logic r);
    logic [W-1:0] e;
    rst = r;
    bus_if.start   = st;
    bus_if.stop    = sp;
    bus_if.oneshot = os;
    bus_if.mask    = mk;
    bus_if.dwell   = dw;
    e = '0;
    if (r) begin
      m_active = 0;
    end else if (!m_active) begin
      if (st && !sp && mk != 8'd0) begin
        m_list.delete();
        for (int i = 0; i < 8; i++) if (mk[i]) m_list.push_back(i);
        m_dwell  = int'(dw);
        m_os     = os;
        m_pos    = 0;
        m_hold   = 1;
        m_active = 1;
        e = mk_exp(1'b0, 1'b0, 1'b1, 1'b1, 3'(m_list[0]));
      end
    end else if (sp) begin
      m_active = 0;
    end else if (m_hold < m_dwell + 1) begin
      m_hold++;
      e = mk_exp(1'b0, 1'b0, 1'b1, 1'b1, 3'(m_list[m_pos]));
    end else begin
      m_hold = 1;
      m_pos++;
      if (m_pos < m_list.size()) begin
        e = mk_exp(1'b0, 1'b0, 1'b1, 1'b1, 3'(m_list[m_pos]));
      end else if (m_os) begin
        m_active = 0;
        e = mk_exp(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
      end else begin
        m_pos = 0;
        e = mk_exp(1'b0, 1'b1, 1'b1, 1'b1, 3'(m_list[0]));
      end
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 8'd0, '0, 1'b0);
  endtask

  task automatic start_scan(input logic [7:0] mk, input logic [DW-1:0] dw, input logic os);
    tick(1'b1, 1'b0, os, mk, dw, 1'b0);
  endtask

  initial begin
    scen = "reset";
    tick(1'b0, 1'b0, 1'b0, 8'd0, '0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 8'hFF, '0, 1'b1);
    idle(2);

    scen = "oneshot_ff";
    start_scan(8'hFF, 8'd0, 1'b1);
    idle(10);

    scen = "mask_zero";
    tick(1'b1, 1'b0, 1'b0, 8'h00, 8'd3, 1'b0);
    idle(2);

    scen = "start_stop_idle";
    tick(1'b1, 1'b1, 1'b0, 8'hA4, 8'd2, 1'b0);
    idle(2);

    scen = "cont_a4";
    start_scan(8'hA4, 8'd2, 1'b0);
    for (int i = 0; i < 30; i++) begin
      // restart requests and changed settings mid-scan must be ignored
      if (i == 7) tick(1'b1, 1'b0, 1'b1, 8'h01, 8'd0, 1'b0);
      else        tick(1'b0, 1'b0, 1'b1, 8'h01, 8'd0, 1'b0);
    end
    tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);
    idle(2);

    scen = "stop_ch5";
    start_scan(8'hA4, 8'd2, 1'b0);
    idle(4);
    tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);
    idle(3);
    scen = "restart";
    start_scan(8'hA4, 8'd2, 1'b0);
    idle(8);
    tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);

    scen = "single_ch";
    start_scan(8'h10, 8'd1, 1'b0);
    idle(11);
    tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);

    scen = "rst_mid";
    start_scan(8'hA4, 8'd0, 1'b0);
    idle(4);
    tick(1'b1, 1'b1, 1'b0, 8'hFF, '0, 1'b1);
    idle(3);

    scen = "dwell_max";
    start_scan(8'h81, 8'hFF, 1'b0);
    idle(600);
    tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);
    scen = "dwell_max_os";
    start_scan(8'h80, 8'hFF, 1'b1);
    idle(260);

    for (int r = 0; r < 6; r++) begin
      logic [7:0]    mk;
      logic [DW-1:0] dw;
      logic          os;
      scen = "random";
      mk = 8'($urandom_range(1, 255));
      dw = DW'($urandom_range(0, 4));
      os = 1'($urandom_range(0, 1));
      start_scan(mk, dw, os);
      for (int i = 0; i < 60; i++) begin
        tick(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 29) == 0),
             1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             DW'($urandom_range(0, 4)), 1'b0);
      end
      tick(1'b0, 1'b1, 1'b0, 8'h00, '0, 1'b0);
    end

    scen = "tail";
    idle(2);
    repeat (2) @(posedge clk);
    #2;
    check_val("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
